// File: rtl/exp4_receptor_medida_pkg.sv
// Shared definitions for the distance-frame receiver: state codes and the
// ASCII values that make up a frame ("ddd#").
package exp4_receptor_medida_pkg;

    typedef enum logic [3:0] {
        ESTADO_OCIOSO            = 4'd0,
        ESTADO_RECEBE_DEZENA     = 4'd1,
        ESTADO_RECEBE_UNIDADE    = 4'd2,
        ESTADO_ESPERA_TERMINADOR = 4'd3,
        ESTADO_VALIDA            = 4'd4,
        ESTADO_ERRO              = 4'd5
    } estado_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NOVE = 8'h39;
    localparam logic [7:0] ASCII_TERM = 8'h23;

    // Debug code reported when the state register holds an unused encoding.
    localparam logic [3:0] DB_INVALIDO = 4'b1111;

    // True for the ASCII digits '0'..'9'.
    function automatic logic eh_digito(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NOVE);
    endfunction

endpackage

// File: rtl/exp4_receptor_medida_contador_timeout.sv
// Inter-byte idle counter. fim is high while the count sits at
// TIMEOUT_CICLOS-1; the owner decides whether that cycle is a timeout.
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 500000,
    parameter int CNT_W          = 19
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT_CICLOS - 1);

    logic [CNT_W-1:0] contagem;

    // Clear has priority over counting so a byte strobe restarts the window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= '0;
        end else if (conta) begin
            contagem <= contagem + CNT_W'(1);
        end
    end

    assign fim = (contagem == LIMITE);

endmodule

// File: rtl/exp4_receptor_medida.sv
// Receive-side frame assembler: turns UART bytes "ddd#" into a validated
// 3-digit BCD distance, flags bad or stalled frames and resynchronises.
// Byte input handshake: dado_recebido is meaningful only in the cycle where
// pronto_rx is high; there is no back-pressure, so every strobe is consumed
// (bytes arriving in valida/erro are dropped). medida_valida is a one-cycle
// strobe with medida stable and valid in that same cycle.
module exp4_receptor_medida
    import exp4_receptor_medida_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 500000,
    parameter int CNT_W          = 19
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  dado_recebido,
    input  logic        pronto_rx,
    output logic [11:0] medida,
    output logic        medida_valida,
    output logic        erro_quadro,
    output logic [3:0]  num_erros,
    output logic [3:0]  db_estado
);

    estado_t    estado;
    estado_t    estado_prox;
    logic       digito;
    logic       terminador;
    logic       em_quadro;
    logic       zera_cnt;
    logic       fim_cnt;
    logic       timeout;
    logic [3:0] buf_centena;
    logic [3:0] buf_dezena;
    logic [3:0] buf_unidade;

    assign digito     = eh_digito(dado_recebido);
    assign terminador = (dado_recebido == ASCII_TERM);

    contador_timeout #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clock(clock),
        .reset(reset),
        .zera (zera_cnt),
        .conta(em_quadro),
        .fim  (fim_cnt)
    );

    // A byte arriving on the last idle cycle wins over the timeout.
    assign timeout = fim_cnt && !pronto_rx;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= ESTADO_OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state logic plus the Moore outputs and timer controls.
    always_comb begin
        estado_prox   = ESTADO_OCIOSO;
        medida_valida = 1'b0;
        em_quadro     = 1'b0;
        db_estado     = DB_INVALIDO;
        case (estado)
            ESTADO_OCIOSO: begin
                db_estado   = 4'd0;
                estado_prox = (pronto_rx && digito) ? ESTADO_RECEBE_DEZENA : ESTADO_OCIOSO;
            end
            ESTADO_RECEBE_DEZENA: begin
                db_estado   = 4'd1;
                em_quadro   = 1'b1;
                estado_prox = ESTADO_RECEBE_DEZENA;
                if (pronto_rx) begin
                    estado_prox = digito ? ESTADO_RECEBE_UNIDADE : ESTADO_ERRO;
                end else if (timeout) begin
                    estado_prox = ESTADO_ERRO;
                end
            end
            ESTADO_RECEBE_UNIDADE: begin
                db_estado   = 4'd2;
                em_quadro   = 1'b1;
                estado_prox = ESTADO_RECEBE_UNIDADE;
                if (pronto_rx) begin
                    estado_prox = digito ? ESTADO_ESPERA_TERMINADOR : ESTADO_ERRO;
                end else if (timeout) begin
                    estado_prox = ESTADO_ERRO;
                end
            end
            ESTADO_ESPERA_TERMINADOR: begin
                db_estado   = 4'd3;
                em_quadro   = 1'b1;
                estado_prox = ESTADO_ESPERA_TERMINADOR;
                if (pronto_rx) begin
                    // A fourth digit is a framing error, not a new frame.
                    estado_prox = terminador ? ESTADO_VALIDA : ESTADO_ERRO;
                end else if (timeout) begin
                    estado_prox = ESTADO_ERRO;
                end
            end
            ESTADO_VALIDA: begin
                db_estado     = 4'd4;
                medida_valida = 1'b1;
                estado_prox   = ESTADO_OCIOSO;
            end
            ESTADO_ERRO: begin
                db_estado   = 4'd5;
                estado_prox = ESTADO_OCIOSO;
            end
            default: begin
                db_estado   = DB_INVALIDO;
                estado_prox = ESTADO_OCIOSO;
            end
        endcase
    end

    // Timer runs only inside a frame and restarts on every received byte.
    assign zera_cnt = pronto_rx || !em_quadro;

    // Digit buffer: kept apart from medida so a broken frame never leaks out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_centena <= 4'd0;
            buf_dezena  <= 4'd0;
            buf_unidade <= 4'd0;
        end else if (pronto_rx && digito) begin
            case (estado)
                ESTADO_OCIOSO:         buf_centena <= dado_recebido[3:0];
                ESTADO_RECEBE_DEZENA:  buf_dezena  <= dado_recebido[3:0];
                ESTADO_RECEBE_UNIDADE: buf_unidade <= dado_recebido[3:0];
                default: ;
            endcase
        end
    end

    // Result and error bookkeeping, updated on entry into valida/erro so the
    // new values are visible during those one-cycle states.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            medida      <= 12'd0;
            erro_quadro <= 1'b0;
            num_erros   <= 4'd0;
        end else if (estado_prox == ESTADO_VALIDA) begin
            medida      <= {buf_centena, buf_dezena, buf_unidade};
            erro_quadro <= 1'b0;
        end else if (estado_prox == ESTADO_ERRO) begin
            erro_quadro <= 1'b1;
            if (num_erros != 4'hF) begin
                num_erros <= num_erros + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_exp4_receptor_medida.sv
// Bench for the frame receiver: directed byte sequences, expected distances
// queued as frames are sent and popped by a monitor on each valid strobe.
module tb_exp4_receptor_medida;

    logic        clock;
    logic        reset;
    logic [7:0]  dado_recebido;
    logic        pronto_rx;
    logic [11:0] medida;
    logic        medida_valida;
    logic        erro_quadro;
    logic [3:0]  num_erros;
    logic [3:0]  db_estado;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q[$];

    exp4_receptor_medida #(
        .TIMEOUT_CICLOS(20),
        .CNT_W         (5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dado_recebido(dado_recebido),
        .pronto_rx    (pronto_rx),
        .medida       (medida),
        .medida_valida(medida_valida),
        .erro_quadro  (erro_quadro),
        .num_erros    (num_erros),
        .db_estado    (db_estado)
    );

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nome, atual, esperado);
        end
    endtask

    // One-cycle byte strobe, followed by idle cycles for 10-cycle spacing.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        dado_recebido = b;
        pronto_rx     = 1'b1;
        @(negedge clock);
        pronto_rx = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    // Terminator that must close a good frame: queue the value, then check
    // the strobe appears in the cycle after '#' and lasts exactly one cycle.
    task automatic send_term(input logic [11:0] esperado);
        exp_q.push_back(esperado);
        @(negedge clock);
        dado_recebido = 8'h23;
        pronto_rx     = 1'b1;
        @(posedge clock);
        #1;
        check("valid_latency", {31'd0, medida_valida}, 32'd1);
        @(negedge clock);
        pronto_rx = 1'b0;
        @(posedge clock);
        #1;
        check("valid_one_cycle", {31'd0, medida_valida}, 32'd0);
        repeat (6) @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: every valid strobe must match the oldest queued frame.
    always @(negedge clock) begin
        if (!reset && medida_valida) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid got=%0h expected=no_pulse", medida);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if (medida !== e) begin
                    failures++;
                    $display("FAIL medida got=%0h expected=%0h", medida, e);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        reset         = 1'b1;
        pronto_rx     = 1'b0;
        dado_recebido = 8'h00;
        repeat (2) @(negedge clock);
        check("rst_estado", {28'd0, db_estado}, 32'd0);
        check("rst_medida", {20'd0, medida}, 32'd0);
        check("rst_valida", {31'd0, medida_valida}, 32'd0);
        check("rst_erro", {31'd0, erro_quadro}, 32'd0);
        check("rst_num_erros", {28'd0, num_erros}, 32'd0);
        reset = 1'b0;

        // Basic frame "123#".
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        send_term(12'h123);
        check("t1_erro", {31'd0, erro_quadro}, 32'd0);
        check("t1_num_erros", {28'd0, num_erros}, 32'd0);

        // Garbage in idle is dropped silently, then "045#".
        send_byte(8'h58);
        check("t2_idle_after_X", {28'd0, db_estado}, 32'd0);
        send_byte(8'h23);
        check("t2_idle_after_hash", {28'd0, db_estado}, 32'd0);
        send_byte(8'h30);
        send_byte(8'h34);
        send_byte(8'h35);
        send_term(12'h045);
        check("t2_num_erros", {28'd0, num_erros}, 32'd0);

        // Timeout: '7','8' then silence; erro 20 edges after the '8' edge.
        send_byte(8'h37);
        check("t3_state_dezena", {28'd0, db_estado}, 32'd1);
        @(negedge clock);
        dado_recebido = 8'h38;
        pronto_rx     = 1'b1;
        @(posedge clock);
        #1;
        pronto_rx = 1'b0;
        check("t3_state_unidade", {28'd0, db_estado}, 32'd2);
        repeat (19) @(posedge clock);
        #1;
        check("t3_before_timeout", {28'd0, db_estado}, 32'd2);
        @(posedge clock);
        #1;
        check("t3_state_erro", {28'd0, db_estado}, 32'd5);
        check("t3_erro_flag", {31'd0, erro_quadro}, 32'd1);
        check("t3_num_erros", {28'd0, num_erros}, 32'd1);
        check("t3_medida_held", {20'd0, medida}, 32'h045);
        @(posedge clock);
        #1;
        check("t3_back_idle", {28'd0, db_estado}, 32'd0);
        send_byte(8'h39);
        send_byte(8'h39);
        send_byte(8'h39);
        send_term(12'h999);
        check("t3_erro_cleared", {31'd0, erro_quadro}, 32'd0);
        check("t3_num_erros_kept", {28'd0, num_erros}, 32'd1);

        // Bad characters in the frame body and a fourth digit.
        pulse_reset();
        send_byte(8'h31);
        send_byte(8'h41);
        check("t4_err1_count", {28'd0, num_erros}, 32'd1);
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        send_byte(8'h34);
        check("t4_err2_count", {28'd0, num_erros}, 32'd2);
        check("t4_erro_flag", {31'd0, erro_quadro}, 32'd1);
        check("t4_4th_digit_no_frame", {28'd0, db_estado}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            send_byte(8'h31);
            send_byte(8'h41);
        end
        check("t4_saturated", {28'd0, num_erros}, 32'hF);

        // Byte landing exactly on the timeout cycle is accepted.
        @(negedge clock);
        dado_recebido = 8'h35;
        pronto_rx     = 1'b1;
        @(posedge clock);
        #1;
        pronto_rx = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        check("t5_still_dezena", {28'd0, db_estado}, 32'd1);
        dado_recebido = 8'h36;
        pronto_rx     = 1'b1;
        @(posedge clock);
        #1;
        pronto_rx = 1'b0;
        check("t5_byte_wins", {28'd0, db_estado}, 32'd2);
        send_byte(8'h37);
        send_term(12'h567);
        check("t5_erro_cleared", {31'd0, erro_quadro}, 32'd0);
        check("t5_num_erros", {28'd0, num_erros}, 32'hF);

        // Asynchronous reset in the middle of a frame.
        send_byte(8'h33);
        send_byte(8'h31);
        check("t6_mid_frame", {28'd0, db_estado}, 32'd2);
        #3;
        reset = 1'b1;
        #1;
        check("t6_rst_estado", {28'd0, db_estado}, 32'd0);
        check("t6_rst_medida", {20'd0, medida}, 32'd0);
        check("t6_rst_erro", {31'd0, erro_quadro}, 32'd0);
        check("t6_rst_num_erros", {28'd0, num_erros}, 32'd0);
        check("t6_rst_valida", {31'd0, medida_valida}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        send_byte(8'h33);
        send_byte(8'h30);
        send_byte(8'h30);
        send_term(12'h300);

        repeat (5) @(negedge clock);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exp4_receptor_medida.md
Name: exp4_receptor_medida

Overview:
- Receive-side control unit for the sensor link: consumes bytes from the UART receiver and reassembles the distance frame the sensor side transmits (3 ASCII digits + '#').
- Outputs a validated 3-digit BCD distance with a one-cycle valid strobe, flags malformed or timed-out frames, and resynchronises on its own.
- Sits between the UART RX block and the display/host logic on the receiving board.

Parameters:
- TIMEOUT_CICLOS, default 500000, is the maximum number of idle cycles allowed between bytes inside a frame (10 ms at 50 MHz).
- CNT_W, default 19, is the width of the timeout counter. It must satisfy 2^CNT_W > TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- dado_recebido  in  8  byte from the UART RX; valid only while pronto_rx=1
- pronto_rx  in  1  one-cycle strobe, new byte available
- medida  out  12  BCD distance {centena,dezena,unidade}; holds the last valid frame
- medida_valida  out  1  one-cycle pulse when medida is updated
- erro_quadro  out  1  sticky error flag; cleared by the next valid frame
- num_erros  out  4  saturating count of rejected frames
- db_estado  out  4  current state code

Behaviour:
- Reset (async, any state): Eatual=ocioso, medida=0, medida_valida=0, erro_quadro=0, num_erros=0, timeout counter=0, digit buffer=0.
- A byte is a digit when it is 8'h30..8'h39; its BCD value is byte[3:0]. The terminator is 8'h23 ('#').
- States and encoding:
  - ocioso=0. pronto_rx&digit: store centena, go to recebe_dezena. pronto_rx&non-digit: discard and stay (resync). No timeout in this state.
  - recebe_dezena=1. pronto_rx&digit: store dezena, go to recebe_unidade. pronto_rx&non-digit: go to erro. Timeout: go to erro.
  - recebe_unidade=2. pronto_rx&digit: store unidade, go to espera_terminador. pronto_rx&non-digit: go to erro. Timeout: go to erro.
  - espera_terminador=3. pronto_rx&'#': go to valida. pronto_rx&any other byte: go to erro. Timeout: go to erro.
  - valida=4. Lasts 1 cycle, then ocioso. medida loaded from the buffer on entry. medida_valida=1 (Moore). erro_quadro cleared.
  - erro=5. Lasts 1 cycle, then ocioso. erro_quadro set on entry. num_erros incremented, saturating at 15.
  - Unused codes 6..15: next state ocioso; db_estado=4'b1111.
- Latency: medida and medida_valida change on the first clock edge after the '#' strobe is sampled, i.e. valid in the cycle following the strobe.
- Timeout counter:
  - Cleared on every pronto_rx and whenever the state is ocioso, valida or erro.
  - Increments each cycle in states 1–3.
  - Timeout fires when the count equals TIMEOUT_CICLOS-1 and pronto_rx=0.
  - If pronto_rx coincides with the timeout cycle, the byte wins and is processed normally.
- pronto_rx in valida or erro: the byte is dropped. UART byte spacing (≥10 bit times) makes this unreachable in normal operation.
- A digit in espera_terminador (a fourth digit) is an error. It does not start a new frame.
- medida is never partially updated. The digit buffer is separate from the medida register.
- db_estado equals the state encoding.

Decomposition:
- Shared include file holds the state encodings (ESTADO_OCIOSO…ESTADO_ERRO), ASCII_ZERO=8'h30, ASCII_NOVE=8'h39 and ASCII_TERM=8'h23.
- One sub-module: contador_timeout, a CNT_W-bit up-counter with zera, conta and fim outputs, parameterised by TIMEOUT_CICLOS.
- FSM, digit buffer, medida register and error counter stay in the top module.

Test Plan:
- Strobes '1','2','3','#' (8'h31,8'h32,8'h33,8'h23) spaced 10 cycles apart: medida=12'h123, medida_valida high exactly 1 cycle after the '#' strobe, erro_quadro=0, num_erros=0.
- Bytes 'X','#','0','4','5','#': 'X' and the first '#' are silently discarded in ocioso; medida=12'h045 with one valid pulse; num_erros=0.
- TIMEOUT_CICLOS=20: '7','8', then silence: state passes 1→2, reaches erro exactly 20 idle cycles after '8'; erro_quadro=1, num_erros=1, medida unchanged. Then '9','9','9','#': medida=12'h999, erro_quadro=0, num_erros stays 1.
- '1','A' (non-digit in recebe_dezena), then '1','2','3','4' (digit in place of terminator): two errors, num_erros=2, medida_valida never pulses. Also 17 consecutive bad frames: num_erros saturates at 4'hF.
- TIMEOUT_CICLOS=20: '5' strobe, then next byte '6' exactly on the timeout cycle: byte accepted, no error. Separately, reset asserted mid-frame (state 2): all outputs return to reset values immediately, and the next full frame '3','0','0','#' gives medida=12'h300.
